// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers
// Optional frame watchdog enabled by defining TX_WATCHDOG_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic                                          clk,
    input  logic                                          reset_n,
    input  logic [NUM_REQ-1:0]                            req,
    input  logic [NUM_REQ*DATA_W-1:0]                     req_data,
    output logic [NUM_REQ-1:0]                            grant,
    output logic                                          tx_start,
    output logic [DATA_W-1:0]                             tx_data,
    input  logic                                          tx_busy,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] owner,
    output logic                                          active,
    output logic                                          wdog_err
);
    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    if (NUM_REQ < 1 || NUM_REQ > 8 || WDOG_CYCLES < 2) begin : g_bad_params
        $error("uart_tx_arbiter: parameter out of range");
    end

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic                tx_start_q, tx_start_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic [OW-1:0]       owner_q, owner_d;
    logic                active_q, active_d;
    logic [OW-1:0]       win;
    logic                progress;
    logic                wdog_hit;

    // Scan owner+1, owner+2, ... so the last winner has the lowest priority.
    function automatic logic [OW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                              input logic [OW-1:0]      last);
        logic [OW-1:0]      w;
        logic               found;
        logic [NUM_REQ-1:0] sh;
        int                 idx;
        w     = last;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last) + i) % NUM_REQ;
            sh  = r >> idx;
            if (!found && sh[0]) begin
                w     = OW'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign win      = rr_pick(req, owner_q);
    assign progress = ((state_q == WAIT_BUSY) && tx_busy) ||
                      ((state_q == WAIT_DONE) && !tx_busy);

`ifdef TX_WATCHDOG_EN
    localparam int CW = $clog2(WDOG_CYCLES) + 1;

    logic [CW-1:0] wdog_cnt_q;
    logic          wdog_err_q;

    assign wdog_hit = (state_q != IDLE) && !progress && (wdog_cnt_q == CW'(WDOG_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdog_cnt_q <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_err_q <= wdog_hit;
            if (state_q == IDLE || progress || wdog_hit) begin
                wdog_cnt_q <= '0;
            end else begin
                wdog_cnt_q <= wdog_cnt_q + 1'b1;
            end
        end
    end

    assign wdog_err = wdog_err_q;
`else
    assign wdog_hit = 1'b0;
    assign wdog_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            owner_q    <= OW'(NUM_REQ - 1);
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            owner_q    <= owner_d;
            active_q   <= active_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = '0;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        owner_d    = owner_q;
        active_d   = active_q;
        case (state_q)
            IDLE: begin
                // A busy transmitter here belongs to someone else; leave it alone.
                if (req != '0 && !tx_busy) begin
                    grant_d    = NUM_REQ'(1) << win;
                    tx_start_d = 1'b1;
                    tx_data_d  = DATA_W'(req_data >> (int'(win) * DATA_W));
                    owner_d    = win;
                    active_d   = 1'b1;
                    state_d    = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (wdog_hit) begin
                    active_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy || wdog_hit) begin
                    active_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                active_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    assign grant    = grant_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign owner    = owner_q;
    assign active   = active_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter with a behavioural arbitration model
module tb_uart_tx_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NR-1:0] req = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0] grant;
    logic          tx_start;
    logic [DW-1:0] tx_data;
    logic          tx_busy;
    logic [1:0]    owner;
    logic          active;
    logic          wdog_err;

    int checks = 0;
    int errors = 0;

    logic model_en = 1'b1;
    logic foreign_busy = 1'b0;
    int   frame_len = 4;
    int   left;

    int ref_owner = NR - 1;

    uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .WDOG_CYCLES(16)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data),
        .grant(grant), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .owner(owner), .active(active), .wdog_err(wdog_err)
    );

    always #5 clk = ~clk;

    // Transmitter model: busy for frame_len cycles starting the cycle after tx_start.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) left <= 0;
        else if (tx_start && model_en) left <= frame_len;
        else if (left > 0) left <= left - 1;
    end
    assign tx_busy = (left != 0) || foreign_busy;

    function automatic int ref_pick(input logic [NR-1:0] m, input int last);
        int j;
        for (int i = 1; i <= NR; i++) begin
            j = (last + i) % NR;
            if (m[j[1:0]]) return j;
        end
        return -1;
    endfunction

    task automatic wait_grant(output int n);
        n = -1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (grant != '0) begin
                n = c;
                return;
            end
        end
    endtask

    task automatic wait_inactive(output int n);
        n = -1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (!active) begin
                n = c;
                return;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        req = '0;
        foreign_busy = 1'b0;
        model_en = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        ref_owner = NR - 1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 6;
        if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b expected 0000", grant); end
        if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
        if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        if (owner !== 2'd3) begin errors++; $display("FAIL reset_owner: got %0d expected 3", owner); end
        if (active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", active); end
        if (wdog_err !== 1'b0) begin errors++; $display("FAIL reset_wdog_err: got %b expected 0", wdog_err); end
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        int n;
        req_data[23:16] = 8'hA5;
        req = 4'b0100;
        frame_len = 10;
        wait_grant(n);
        req = '0;
        checks += 6;
        if (n !== 1) begin errors++; $display("FAIL single_latency: got %0d cycles expected 1", n); end
        if (grant !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b expected 0100", grant); end
        if (tx_start !== 1'b1) begin errors++; $display("FAIL single_tx_start: got %b expected 1", tx_start); end
        if (tx_data !== 8'hA5) begin errors++; $display("FAIL single_tx_data: got %h expected a5", tx_data); end
        if (owner !== 2'd2) begin errors++; $display("FAIL single_owner: got %0d expected 2", owner); end
        if (active !== 1'b1) begin errors++; $display("FAIL single_active: got %b expected 1", active); end
        @(negedge clk);
        checks++;
        if (grant !== 4'b0000 || tx_start !== 1'b0) begin
            errors++; $display("FAIL single_pulse_width: got grant=%b tx_start=%b expected 0000/0", grant, tx_start);
        end
        wait_inactive(n);
        checks += 2;
        if (n !== 11) begin errors++; $display("FAIL single_active_len: got %0d expected 11", n); end
        if (tx_data !== 8'hA5) begin errors++; $display("FAIL single_tx_data_hold: got %h expected a5", tx_data); end
    endtask

    task automatic test_all_requesting();
        int n;
        int lprev;
        int order [5] = '{0, 1, 2, 3, 0};
        logic [7:0] bytes [4] = '{8'h10, 8'h21, 8'h32, 8'h43};
        logic [3:0] eg;
        do_reset();
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = bytes[i];
        req = 4'b1111;
        lprev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_grant(n);
            eg = 4'b0001 << order[k];
            checks += 4;
            if (grant !== eg) begin errors++; $display("FAIL all_grant[%0d]: got %b expected %b", k, grant, eg); end
            if (tx_data !== bytes[order[k]]) begin errors++; $display("FAIL all_tx_data[%0d]: got %h expected %h", k, tx_data, bytes[order[k]]); end
            if (owner !== 2'(order[k])) begin errors++; $display("FAIL all_owner[%0d]: got %0d expected %0d", k, owner, order[k]); end
            if (n !== ((k == 0) ? 1 : lprev + 3)) begin
                errors++; $display("FAIL all_spacing[%0d]: got %0d expected %0d", k, n, (k == 0) ? 1 : lprev + 3);
            end
            lprev = $urandom_range(1, 6);
            frame_len = lprev;
        end
        req = '0;
        wait_inactive(n);
    endtask

    task automatic test_fairness();
        int n;
        do_reset();
        req_data = 32'h44_33_22_11;
        frame_len = 3;
        req = 4'b0010;
        wait_grant(n);
        req = '0;
        checks++;
        if (owner !== 2'd1) begin errors++; $display("FAIL fair_setup_owner: got %0d expected 1", owner); end
        wait_inactive(n);
        req = 4'b0011;
        wait_grant(n);
        req = 4'b0010;
        checks += 2;
        if (grant !== 4'b0001) begin errors++; $display("FAIL fair_first: got %b expected 0001", grant); end
        if (tx_data !== 8'h11) begin errors++; $display("FAIL fair_first_data: got %h expected 11", tx_data); end
        wait_grant(n);
        req = '0;
        checks += 2;
        if (grant !== 4'b0010) begin errors++; $display("FAIL fair_second: got %b expected 0010", grant); end
        if (tx_data !== 8'h22) begin errors++; $display("FAIL fair_second_data: got %h expected 22", tx_data); end
        wait_inactive(n);
    endtask

    task automatic test_busy_holdoff();
        int n;
        int early;
        @(negedge clk);
        foreign_busy = 1'b1;
        req = 4'b0001;
        early = 0;
        repeat (6) begin
            @(negedge clk);
            if (grant !== 4'b0000 || active !== 1'b0) early++;
        end
        checks++;
        if (early !== 0) begin errors++; $display("FAIL holdoff_no_grant: got %0d granting cycles expected 0", early); end
        foreign_busy = 1'b0;
        wait_grant(n);
        req = '0;
        checks += 2;
        if (n !== 1) begin errors++; $display("FAIL holdoff_latency: got %0d expected 1", n); end
        if (grant !== 4'b0001) begin errors++; $display("FAIL holdoff_grant: got %b expected 0001", grant); end
        wait_inactive(n);
    endtask

    task automatic test_reset_midframe();
        int n;
        frame_len = 20;
        req = 4'b0010;
        wait_grant(n);
        req = '0;
        repeat (5) @(negedge clk);
        checks++;
        if (active !== 1'b1 || tx_busy !== 1'b1) begin
            errors++; $display("FAIL midframe_setup: got active=%b busy=%b expected 1/1", active, tx_busy);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (grant !== 4'b0000 || tx_start !== 1'b0 || tx_data !== 8'h00 || owner !== 2'd3 || active !== 1'b0 || wdog_err !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset_values: got grant=%b start=%b data=%h owner=%0d active=%b wdog=%b expected 0000/0/00/3/0/0",
                     grant, tx_start, tx_data, owner, active, wdog_err);
        end
        @(negedge clk);
        checks++;
        if (tx_start !== 1'b0) begin errors++; $display("FAIL midframe_no_restart: got %b expected 0", tx_start); end
        reset_n = 1'b1;
        frame_len = 3;
        req = 4'b0001;
        wait_grant(n);
        req = '0;
        checks += 2;
        if (grant !== 4'b0001) begin errors++; $display("FAIL midframe_after_grant: got %b expected 0001", grant); end
        if (n !== 1) begin errors++; $display("FAIL midframe_after_latency: got %0d expected 1", n); end
        wait_inactive(n);
    endtask

    task automatic test_random();
        int n;
        int lprev;
        int exp_w;
        logic [NR-1:0] pm;
        logic [NR-1:0] keep;
        logic [NR-1:0] join_m;
        logic [7:0] bytes [NR];
        logic [3:0] eg;
        do_reset();
        for (int i = 0; i < NR; i++) bytes[i] = 8'($urandom);
        pm = 4'($urandom_range(1, 15));
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = bytes[i];
        req = pm;
        lprev = 0;
        for (int k = 0; k < 40; k++) begin
            wait_grant(n);
            exp_w = ref_pick(pm, ref_owner);
            eg = 4'b0001 << exp_w;
            checks += 4;
            if (grant !== eg) begin errors++; $display("FAIL rand_grant[%0d]: got %b expected %b (req %b)", k, grant, eg, pm); end
            if (tx_data !== bytes[exp_w]) begin errors++; $display("FAIL rand_tx_data[%0d]: got %h expected %h", k, tx_data, bytes[exp_w]); end
            if (owner !== 2'(exp_w)) begin errors++; $display("FAIL rand_owner[%0d]: got %0d expected %0d", k, owner, exp_w); end
            if (n !== ((k == 0) ? 1 : lprev + 3)) begin
                errors++; $display("FAIL rand_spacing[%0d]: got %0d expected %0d", k, n, (k == 0) ? 1 : lprev + 3);
            end
            ref_owner = exp_w;
            lprev = $urandom_range(1, 8);
            frame_len = lprev;
            keep = 4'($urandom) | 4'($urandom);
            join_m = 4'($urandom) & 4'($urandom);
            for (int i = 0; i < NR; i++) begin
                if (i == exp_w) begin
                    pm[i] = $urandom_range(0, 1) == 1;
                    if (pm[i]) bytes[i] = 8'($urandom);
                end else if (!pm[i] && join_m[i]) begin
                    pm[i] = 1'b1;
                    bytes[i] = 8'($urandom);
                end else if (pm[i] && !keep[i]) begin
                    pm[i] = 1'b0;
                end
            end
            if (pm == '0) pm[$urandom_range(0, NR - 1)] = 1'b1;
            for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = bytes[i];
            req = pm;
        end
        req = '0;
        wait_inactive(n);
    endtask

    task automatic test_watchdog();
        int n;
        int c;
        do_reset();
        model_en = 1'b0;
        req = 4'b0010;
        wait_grant(n);
`ifdef TX_WATCHDOG_EN
        req = '0;
        c = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (wdog_err) begin
                c = i;
                break;
            end
        end
        checks += 2;
        if (c !== 16) begin errors++; $display("FAIL wdog_delay: got %0d expected 16", c); end
        if (active !== 1'b0) begin errors++; $display("FAIL wdog_active: got %b expected 0", active); end
        @(negedge clk);
        checks++;
        if (wdog_err !== 1'b0) begin errors++; $display("FAIL wdog_pulse_width: got %b expected 0", wdog_err); end
        model_en = 1'b1;
        frame_len = 3;
        req = 4'b0110;
        wait_grant(n);
        req = '0;
        checks += 2;
        if (grant !== 4'b0100) begin errors++; $display("FAIL wdog_next_grant: got %b expected 0100", grant); end
        if (n !== 1) begin errors++; $display("FAIL wdog_next_latency: got %0d expected 1", n); end
        wait_inactive(n);
`else
        req = 4'b0100;
        c = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (wdog_err !== 1'b0 || grant !== 4'b0000 || active !== 1'b1) c++;
        end
        checks++;
        if (c !== 0) begin errors++; $display("FAIL hang_no_wdog: got %0d bad cycles expected 0", c); end
        do_reset();
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_requesting();
        test_fairness();
        test_busy_holdoff();
        test_reset_midframe();
        test_random();
        test_watchdog();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
